// File: rtl/rv_regfile_pkg.sv
// Shared types and sizing for the integer register file write side.
// The occupancy FSM encodes its state as the FIFO entry count.
package rv_regfile_pkg;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/regfile_write_port_if.sv
// Write-back request channel from the WB stage into the register file write port.
// valid/ready: a request transfers on a rising edge where wb_valid && wb_ready;
// while wb_valid=1 and wb_ready=0 the master holds wb_rd and wb_data stable.
interface regfile_write_port_if;
  import rv_regfile_pkg::*;

  logic            wb_valid;
  logic            wb_ready;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;

  modport master (output wb_valid, output wb_rd, output wb_data, input wb_ready);
  modport slave  (input wb_valid, input wb_rd, input wb_data, output wb_ready);

endinterface

// File: rtl/regfile_write_port_dec5to32.sv
// One-hot write-enable decoder; all outputs low unless the drain condition enables it.
module dec5to32
  import rv_regfile_pkg::*;
(
  input  logic [AW-1:0]   i_addr,
  input  logic            i_en,
  output logic [NREG-1:0] o_we
);

  always_comb begin
    o_we = '0;
    if (i_en) o_we[i_addr] = 1'b1;
  end

endmodule

// File: rtl/regfile_write_port.sv
// Register file write port: a 2-entry request FIFO drained one entry per cycle
// into 32x32 storage, with a pending flag and per-register busy mask for hazard stalls.
module regfile_write_port
  import rv_regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_write_port_if.slave  wb,
  input  logic                 wr_hold,
  output logic [NREG*XLEN-1:0] regs_flat,
  output logic                 pending,
  output logic [NREG-1:0]      busy_mask,
  output logic [1:0]           dbg_state
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]      r_state;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [DEPTH-1:0] r_vld;
  wb_req_t         r_fifo [DEPTH];
  logic [XLEN-1:0] r_regs [NREG];

  wb_req_t         w_head;
  logic            w_push;
  logic            w_pop;
  logic            w_we_en;
  logic [NREG-1:0] w_we;
  logic [1:0]      w_state_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready looks only at occupancy, never at a same-cycle pop, to keep it off the drain path.
  assign wb.wb_ready = rst_n && (r_state != ST_FULL);
  assign w_push      = wb.wb_valid && wb.wb_ready;
  assign w_head      = r_fifo[r_rd_ptr];
  assign w_pop       = (r_state != ST_EMPTY) && !wr_hold;
  assign w_we_en     = w_pop && (w_head.rd != '0);

  dec5to32 u_dec (
    .i_addr (w_head.rd),
    .i_en   (w_we_en),
    .o_we   (w_we)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_push) w_state_nxt = ST_ONE;
      ST_ONE: begin
        if (w_push && !w_pop)      w_state_nxt = ST_FULL;
        else if (!w_push && w_pop) w_state_nxt = ST_EMPTY;
      end
      ST_FULL:  if (w_pop) w_state_nxt = ST_ONE;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_EMPTY;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_vld    <= '0;
      for (int i = 0; i < DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= ptr_inc(r_rd_ptr);
      end
      // Push and pop never touch the same slot: a pop needs count>=1, a push needs count<DEPTH.
      if (w_push) begin
        r_fifo[r_wr_ptr] <= '{rd: wb.wb_rd, data: wb.wb_data};
        r_vld[r_wr_ptr]  <= 1'b1;
        r_wr_ptr         <= ptr_inc(r_wr_ptr);
      end
    end
  end

  // Register 0 is never enabled by the decoder, so it holds its reset value forever.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) r_regs[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (w_we[r]) r_regs[r] <= w_head.data;
      end
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i]) busy_mask[r_fifo[i].rd] = 1'b1;
    end
    busy_mask[0] = 1'b0;
  end

  for (genvar r = 0; r < NREG; r++) begin : g_flat
    assign regs_flat[r*XLEN +: XLEN] = r_regs[r];
  end

  assign pending   = (r_state != ST_EMPTY);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_regfile_write_port.sv
// Bench for regfile_write_port: directed scenarios plus randomized traffic
// compared against a queue-and-array model of the write port.
module tb_regfile_write_port;
  import rv_regfile_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic                 wr_hold;
  logic [NREG*XLEN-1:0] regs_flat;
  logic                 pending;
  logic [NREG-1:0]      busy_mask;
  logic [1:0]           dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  regfile_write_port_if wb_if ();

  regfile_write_port dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb        (wb_if),
    .wr_hold   (wr_hold),
    .regs_flat (regs_flat),
    .pending   (pending),
    .busy_mask (busy_mask),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  wb_req_t         m_q [$];
  logic [XLEN-1:0] m_regs [NREG];
  bit              m_last_push;

  initial begin
    for (int r = 0; r < NREG; r++) m_regs[r] = '0;
    m_last_push = 0;
  end

  always @(posedge clk) begin
    bit      push;
    bit      pop;
    wb_req_t e;
    push = wb_if.wb_valid && rst_n && (m_q.size() < DEPTH);
    pop  = (m_q.size() > 0) && !wr_hold;
    if (!rst_n) begin
      m_q.delete();
      for (int r = 0; r < NREG; r++) m_regs[r] = '0;
      push = 0;
    end else begin
      if (pop) begin
        e = m_q.pop_front();
        if (e.rd != 0) m_regs[e.rd] = e.data;
      end
      if (push) m_q.push_back('{rd: wb_if.wb_rd, data: wb_if.wb_data});
    end
    m_last_push = push;
  end

  function automatic logic [NREG*XLEN-1:0] m_flat();
    logic [NREG*XLEN-1:0] f;
    for (int r = 0; r < NREG; r++) f[r*XLEN +: XLEN] = m_regs[r];
    return f;
  endfunction

  function automatic logic [NREG-1:0] m_busy();
    logic [NREG-1:0] b = '0;
    foreach (m_q[i]) if (m_q[i].rd != 0) b[m_q[i].rd] = 1'b1;
    return b;
  endfunction

  function automatic logic [XLEN-1:0] dut_reg(input int r);
    return regs_flat[r*XLEN +: XLEN];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drv(input logic v, input logic [AW-1:0] rd, input logic [XLEN-1:0] d,
                     input logic h);
    wb_if.wb_valid = v;
    wb_if.wb_rd    = rd;
    wb_if.wb_data  = d;
    wr_hold        = h;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drv(0, 0, 0, 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    drv(1, 9, 32'hA5A5_0001, 0); cyc();
    drv(1, 10, 32'hA5A5_0002, 0); cyc();
    drv(0, 0, 0, 0); cyc(); cyc();
    n_checks++;
    if (dut_reg(9) !== 32'hA5A5_0001) begin
      n_errors++; $display("FAIL pre_reset_r9: got %h want a5a50001", dut_reg(9));
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (wb_if.wb_ready !== 1'b0) begin
      n_errors++; $display("FAIL reset_ready_comb: got %b want 0", wb_if.wb_ready);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if (regs_flat !== '0 || wb_if.wb_ready !== 1'b0 || pending !== 1'b0 || busy_mask !== '0) begin
        n_errors++;
        $display("FAIL reset_hold[%0d]: r9=%h r10=%h ready=%b pending=%b busy=%h want all 0",
                 i, dut_reg(9), dut_reg(10), wb_if.wb_ready, pending, busy_mask);
      end
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (wb_if.wb_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_release_ready: got %b want 1", wb_if.wb_ready);
    end
  endtask

  task automatic test_single_write();
    cyc();
    drv(1, 5, 32'hDEAD_BEEF, 0);
    cyc();
    n_checks++;
    if (pending !== 1'b1 || busy_mask !== 32'h0000_0020 || dut_reg(5) !== 32'h0) begin
      n_errors++;
      $display("FAIL single_inflight: pending=%b busy=%h r5=%h want 1/00000020/00000000",
               pending, busy_mask, dut_reg(5));
    end
    drv(0, 0, 0, 0);
    cyc();
    n_checks++;
    if (dut_reg(5) !== 32'hDEAD_BEEF || busy_mask !== '0 || pending !== 1'b0) begin
      n_errors++;
      $display("FAIL single_done: r5=%h busy=%h pending=%b want deadbeef/0/0",
               dut_reg(5), busy_mask, pending);
    end
  endtask

  task automatic test_write_r0();
    drv(1, 0, 32'h1234_5678, 0);
    cyc();
    n_checks++;
    if (pending !== 1'b1 || busy_mask !== '0 || dut_reg(0) !== 32'h0) begin
      n_errors++;
      $display("FAIL r0_inflight: pending=%b busy=%h r0=%h want 1/0/0", pending, busy_mask, dut_reg(0));
    end
    drv(0, 0, 0, 0);
    cyc();
    n_checks++;
    if (pending !== 1'b0 || busy_mask !== '0 || dut_reg(0) !== 32'h0 || dbg_state !== ST_EMPTY) begin
      n_errors++;
      $display("FAIL r0_done: pending=%b busy=%h r0=%h state=%0d want 0/0/0/0",
               pending, busy_mask, dut_reg(0), dbg_state);
    end
  endtask

  task automatic test_hold_backpressure();
    drv(1, 1, 32'h11, 1); cyc();
    drv(1, 2, 32'h22, 1); cyc();
    n_checks++;
    if (dbg_state !== ST_FULL || wb_if.wb_ready !== 1'b0 || busy_mask !== 32'h0000_0006) begin
      n_errors++;
      $display("FAIL hold_full: state=%0d ready=%b busy=%h want 2/0/00000006",
               dbg_state, wb_if.wb_ready, busy_mask);
    end
    drv(1, 3, 32'h33, 1); cyc();
    n_checks++;
    if (wb_if.wb_ready !== 1'b0 || busy_mask !== 32'h0000_0006 || dut_reg(1) !== 32'h0) begin
      n_errors++;
      $display("FAIL hold_stall: ready=%b busy=%h r1=%h want 0/00000006/0",
               wb_if.wb_ready, busy_mask, dut_reg(1));
    end
    drv(1, 3, 32'h33, 0); cyc();
    n_checks++;
    if (dut_reg(1) !== 32'h11 || dut_reg(2) !== 32'h0 || busy_mask !== 32'h0000_0004 ||
        dbg_state !== ST_ONE || wb_if.wb_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL drain_first: r1=%h r2=%h busy=%h state=%0d ready=%b want 11/0/00000004/1/1",
               dut_reg(1), dut_reg(2), busy_mask, dbg_state, wb_if.wb_ready);
    end
    cyc();
    n_checks++;
    if (dut_reg(2) !== 32'h22 || busy_mask !== 32'h0000_0008 || dbg_state !== ST_ONE) begin
      n_errors++;
      $display("FAIL drain_second: r2=%h busy=%h state=%0d want 22/00000008/1",
               dut_reg(2), busy_mask, dbg_state);
    end
    drv(0, 0, 0, 0); cyc();
    n_checks++;
    if (dut_reg(3) !== 32'h33 || pending !== 1'b0) begin
      n_errors++; $display("FAIL drain_third: r3=%h pending=%b want 33/0", dut_reg(3), pending);
    end
  endtask

  task automatic test_back_to_back();
    drv(1, 7, 32'h1, 0); cyc();
    n_checks++;
    if (busy_mask !== 32'h0000_0080) begin
      n_errors++; $display("FAIL b2b_busy: got %h want 00000080", busy_mask);
    end
    drv(1, 7, 32'h2, 0); cyc();
    n_checks++;
    if (dut_reg(7) !== 32'h1 || dbg_state !== ST_ONE || busy_mask !== 32'h0000_0080) begin
      n_errors++;
      $display("FAIL b2b_overlap: r7=%h state=%0d busy=%h want 1/1/00000080",
               dut_reg(7), dbg_state, busy_mask);
    end
    drv(0, 0, 0, 0); cyc();
    n_checks++;
    if (dut_reg(7) !== 32'h2 || pending !== 1'b0) begin
      n_errors++; $display("FAIL b2b_final: r7=%h pending=%b want 2/0", dut_reg(7), pending);
    end
  endtask

  task automatic test_reset_mid();
    drv(1, 4, 32'h44, 0); cyc();
    drv(1, 6, 32'h66, 0); cyc();
    drv(0, 0, 0, 0); cyc();
    n_checks++;
    if (dut_reg(4) !== 32'h44 || dut_reg(6) !== 32'h66) begin
      n_errors++; $display("FAIL mid_prefill: r4=%h r6=%h want 44/66", dut_reg(4), dut_reg(6));
    end
    drv(1, 4, 32'hAAAA, 1); cyc();
    drv(1, 6, 32'hBBBB, 1); cyc();
    drv(0, 0, 0, 1);
    n_checks++;
    if (dbg_state !== ST_FULL || busy_mask !== 32'h0000_0050) begin
      n_errors++; $display("FAIL mid_full: state=%0d busy=%h want 2/00000050", dbg_state, busy_mask);
    end
    rst_n = 1'b0; cyc();
    n_checks++;
    if (pending !== 1'b0 || busy_mask !== '0 || dbg_state !== ST_EMPTY) begin
      n_errors++;
      $display("FAIL mid_reset: pending=%b busy=%h state=%0d want 0/0/0", pending, busy_mask, dbg_state);
    end
    rst_n = 1'b1;
    drv(0, 0, 0, 0); cyc(); cyc();
    n_checks++;
    if (dut_reg(4) !== 32'h0 || dut_reg(6) !== 32'h0 || pending !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_after: r4=%h r6=%h pending=%b want 0/0/0", dut_reg(4), dut_reg(6), pending);
    end
  endtask

  task automatic test_random();
    logic [NREG*XLEN-1:0] exp_flat;
    logic [NREG-1:0]      exp_busy;
    logic                 exp_ready;
    for (int t = 0; t < 500; t++) begin
      cyc();
      exp_flat  = m_flat();
      exp_busy  = m_busy();
      exp_ready = rst_n && (m_q.size() < DEPTH);
      n_checks++;
      if (regs_flat !== exp_flat) begin
        n_errors++; $display("FAIL rand_regs[%0d]: storage differs from model", t);
      end
      n_checks++;
      if (wb_if.wb_ready !== exp_ready || pending !== (m_q.size() != 0) ||
          busy_mask !== exp_busy || dbg_state !== 2'(m_q.size())) begin
        n_errors++;
        $display("FAIL rand_ctrl[%0d]: ready=%b pending=%b busy=%h state=%0d want %b/%b/%h/%0d",
                 t, wb_if.wb_ready, pending, busy_mask, dbg_state,
                 exp_ready, (m_q.size() != 0), exp_busy, m_q.size());
      end
      rst_n   = ($urandom_range(0, 59) != 0);
      wr_hold = ($urandom_range(0, 3) == 0);
      // A request not yet accepted keeps its payload until it transfers.
      if (!(wb_if.wb_valid && !m_last_push)) begin
        wb_if.wb_valid = ($urandom_range(0, 3) != 0);
        wb_if.wb_rd    = AW'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(0, NREG - 1));
        wb_if.wb_data  = $urandom;
      end
    end
    rst_n = 1'b1;
    drv(0, 0, 0, 0);
    repeat (3) cyc();
    n_checks++;
    if (regs_flat !== m_flat() || pending !== 1'b0) begin
      n_errors++; $display("FAIL rand_drain: final storage or pending differs from model");
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    drv(0, 0, 0, 0);
    test_reset();
    test_single_write();
    test_write_r0();
    test_hold_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
